// File: rtl/window_pingpong_buffer.sv
// Two-bank ping-pong frame buffer. Frames are written row-major; WIN x WIN windows are read back.
// Define WINBUF_ZERO_PAD_EN to read out-of-frame pixels as zero instead of raising rd_err.
module window_pingpong_buffer #(
  parameter int unsigned H     = 13,
  parameter int unsigned W     = 13,
  parameter int unsigned DW    = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned WIN   = 4,
  localparam int unsigned CW   = $clog2((H > W) ? H : W) + 1,
  localparam int unsigned FW   = $clog2(H * W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [LANES*DW-1:0]   wr_data,
  input  logic                  rd_req,
  input  logic [CW-1:0]         rd_row,
  input  logic [CW-1:0]         rd_col,
  output logic                  rd_valid,
  output logic [WIN*WIN*DW-1:0] rd_data,
  output logic                  rd_err,
  output logic                  bank_rdy,
  // 'release' is a reserved word, hence rd_release.
  input  logic                  rd_release,
  output logic [FW-1:0]         fill_cnt
);

  localparam int unsigned NPIX = H * W;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned PW   = $clog2(NPIX + LANES + 1);
  localparam int unsigned NE   = WIN * WIN;
  localparam int unsigned RW   = CW + 1;

  typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull} bank_st_e;

  bank_st_e         bank_st_q [2];
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [PW-1:0]    ptr_q;
  logic             rd_valid_q;
  logic             rd_err_q;
  logic [NE*DW-1:0] rd_data_q;
  logic [DW-1:0]    mem [2][NPIX];

  logic             wr_fire;
  logic             wr_last;
  logic             rd_fire;
  logic             rel_fire;
  logic [NE*DW-1:0] win_data;
  logic             win_err;

  assign wr_ready = (bank_st_q[wr_bank_q] != BankFull);
  assign bank_rdy = (bank_st_q[rd_bank_q] == BankFull);
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_last  = (ptr_q + PW'(LANES)) >= PW'(NPIX);
  assign rd_fire  = rd_req & bank_rdy;
  assign rel_fire = rd_release & bank_rdy;
  assign fill_cnt = FW'(ptr_q);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

  // Write completion and release never target the same bank: one needs it FULL, the other not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BankEmpty;
      bank_st_q[1] <= BankEmpty;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      ptr_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= win_data;
        rd_err_q  <= win_err;
      end
      if (wr_fire) begin
        if (wr_last) begin
          bank_st_q[wr_bank_q] <= BankFull;
          wr_bank_q            <= ~wr_bank_q;
          ptr_q                <= '0;
        end else begin
          bank_st_q[wr_bank_q] <= BankFilling;
          ptr_q                <= ptr_q + PW'(LANES);
        end
      end
      if (rel_fire) begin
        bank_st_q[rd_bank_q] <= BankEmpty;
        rd_bank_q            <= ~rd_bank_q;
      end
    end
  end

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if ((ptr_q + PW'(l)) < PW'(NPIX)) begin
          mem[wr_bank_q][AW'(ptr_q + PW'(l))] <= wr_data[l*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    logic [RW-1:0] r;
    logic [RW-1:0] c;
    logic          oob;
    logic [DW-1:0] pix;
    win_data = '0;
    win_err  = 1'b0;
    r        = '0;
    c        = '0;
    oob      = 1'b0;
    pix      = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      for (int unsigned j = 0; j < WIN; j++) begin
        // One extra sign bit keeps row+i / col+j from wrapping.
        r   = {rd_row[CW-1], rd_row} + RW'(i);
        c   = {rd_col[CW-1], rd_col} + RW'(j);
        oob = r[RW-1] | c[RW-1] | (r >= RW'(H)) | (c >= RW'(W));
        pix = '0;
        if (!oob) begin
          pix = mem[rd_bank_q][AW'(r[CW-1:0]) * AW'(W) + AW'(c[CW-1:0])];
        end
        win_data[(WIN*i+j)*DW +: DW] = pix;
`ifndef WINBUF_ZERO_PAD_EN
        if (oob) begin
          win_err = 1'b1;
        end
`endif
      end
    end
`ifndef WINBUF_ZERO_PAD_EN
    if (win_err) begin
      win_data = '0;
    end
`endif
  end

endmodule

// File: tb/tb_window_pingpong_buffer.sv
// Scoreboard bench for window_pingpong_buffer: a behavioural bank/pixel model predicts every
// window and status output; expected windows are queued at request time and popped on rd_valid.
module tb_window_pingpong_buffer;

  localparam int H = 13, W = 13, DW = 8, LANES = 4, WIN = 4;
  localparam int CW = 5, FW = 8, NPIX = H * W, NE = WIN * WIN;

  typedef logic [NE*DW-1:0] val_t;
  typedef struct {
    val_t data;
    logic err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [LANES*DW-1:0] wr_data = '0;
  logic                rd_req = 1'b0;
  logic [CW-1:0]       rd_row = '0;
  logic [CW-1:0]       rd_col = '0;
  logic                rd_valid;
  val_t                rd_data;
  logic                rd_err;
  logic                bank_rdy;
  logic                rd_release = 1'b0;
  logic [FW-1:0]       fill_cnt;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] mm [2][NPIX];
  logic          m_full [2];
  logic          m_wr, m_rd;
  int            m_ptr;
  int            cur_row, cur_col;
  val_t          last_data;

  always #5 clk = ~clk;

  window_pingpong_buffer #(.H(H), .W(W), .DW(DW), .LANES(LANES), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .bank_rdy  (bank_rdy),
    .rd_release(rd_release),
    .fill_cnt  (fill_cnt)
  );

  task automatic check_eq(input string tag, input val_t got, input val_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_win(input logic b, input int row, input int col);
    exp_t x;
    int   r, c;
    x.data = '0;
    x.err  = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        r = row + i;
        c = col + j;
        if (r < 0 || r >= H || c < 0 || c >= W) begin
`ifndef WINBUF_ZERO_PAD_EN
          x.err = 1'b1;
`endif
        end else begin
          x.data[(WIN*i+j)*DW +: DW] = mm[b][r*W+c];
        end
      end
    end
    if (x.err) x.data = '0;
    return x;
  endfunction

  // One clock: predict, advance the model, then compare everything observable.
  task automatic tick();
    logic aw, ar, arel, pw, pr;
    exp_t e;
    pw   = m_wr;
    pr   = m_rd;
    aw   = wr_valid && !m_full[pw];
    ar   = rd_req && m_full[pr];
    arel = rd_release && m_full[pr];
    if (ar) sb.push_back(model_win(pr, cur_row, cur_col));
    @(posedge clk);
    if (aw) begin
      for (int l = 0; l < LANES; l++) begin
        if (m_ptr + l < NPIX) mm[pw][m_ptr+l] = wr_data[l*DW +: DW];
      end
      if (m_ptr + LANES >= NPIX) begin
        m_full[pw] = 1'b1;
        m_wr       = ~pw;
        m_ptr      = 0;
      end else begin
        m_ptr += LANES;
      end
    end
    if (arel) begin
      m_full[pr] = 1'b0;
      m_rd       = ~pr;
    end
    #1;
    check_eq("rd_valid", val_t'(rd_valid), val_t'(ar));
    if (rd_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("rd_data", rd_data, e.data);
      check_eq("rd_err", val_t'(rd_err), val_t'(e.err));
      last_data = e.data;
    end
    check_eq("wr_ready", val_t'(wr_ready), val_t'(!m_full[m_wr]));
    check_eq("bank_rdy", val_t'(bank_rdy), val_t'(m_full[m_rd]));
    check_eq("fill_cnt", val_t'(fill_cnt), val_t'(m_ptr));
  endtask

  task automatic do_reset();
    wr_valid   = 1'b0;
    rd_req     = 1'b0;
    rd_release = 1'b0;
    rst_n      = 1'b0;
    m_full[0]  = 1'b0;
    m_full[1]  = 1'b0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    m_ptr      = 0;
    sb.delete();
    @(posedge clk);
    #1;
    check_eq("rst_rd_valid", val_t'(rd_valid), '0);
    check_eq("rst_rd_err", val_t'(rd_err), '0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_fill_cnt", val_t'(fill_cnt), '0);
    check_eq("rst_bank_rdy", val_t'(bank_rdy), '0);
    check_eq("rst_wr_ready", val_t'(wr_ready), val_t'(1'b1));
    rst_n = 1'b1;
  endtask

  // Pixel at address a of a frame with this base reads (a + base) mod 256.
  task automatic fill(input int base, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < LANES; l++) wr_data[l*DW +: DW] = 8'((base + m_ptr + l) % 256);
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic set_rd(input int row, input int col);
    cur_row = row;
    cur_col = col;
    rd_row  = 5'(row);
    rd_col  = 5'(col);
  endtask

  task automatic rd(input int row, input int col);
    set_rd(row, col);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    do_reset();

    rd(2, 3);

    fill(1, 43);
    check_eq("t1_bank_rdy", val_t'(bank_rdy), val_t'(1'b1));
    check_eq("t1_fill_cnt", val_t'(fill_cnt), '0);
    check_eq("t1_wr_ready", val_t'(wr_ready), val_t'(1'b1));

    rd(2, 3);
    check_eq("t2_elem0", val_t'(rd_data[7:0]), val_t'(30));
    check_eq("t2_elem15", val_t'(rd_data[127:120]), val_t'(72));
    check_eq("t2_err", val_t'(rd_err), '0);
    tick();
    check_eq("t2_hold", rd_data, last_data);

    rd(9, 9);
    rd(10, 10);
`ifdef WINBUF_ZERO_PAD_EN
    rd(-1, -1);
    check_eq("t4_elem0", val_t'(rd_data[7:0]), '0);
    check_eq("t4_elem5", val_t'(rd_data[47:40]), val_t'(1));
    check_eq("t4_err", val_t'(rd_err), '0);
`else
    check_eq("t4_err", val_t'(rd_err), val_t'(1'b1));
    check_eq("t4_data", rd_data, '0);
    rd(-1, -1);
`endif

    rd_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_rd(int'($urandom_range(15)) - 3, int'($urandom_range(15)) - 3);
      tick();
    end
    rd_req = 1'b0;

    fill(101, 43);
    check_eq("t3_wr_ready_full", val_t'(wr_ready), '0);
    fill(7, 1);
    check_eq("t3_stall_fill", val_t'(fill_cnt), '0);
    rd(0, 0);

    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    check_eq("t3_bank_rdy", val_t'(bank_rdy), val_t'(1'b1));
    check_eq("t3_wr_ready", val_t'(wr_ready), val_t'(1'b1));
    rd(2, 3);
    check_eq("t3_frame2", val_t'(rd_data[7:0]), val_t'(130));

    // Last beat of frame 3, window request and release all in one cycle.
    fill(201, 42);
    for (int l = 0; l < LANES; l++) wr_data[l*DW +: DW] = 8'((201 + m_ptr + l) % 256);
    wr_valid   = 1'b1;
    rd_release = 1'b1;
    set_rd(2, 3);
    rd_req     = 1'b1;
    tick();
    wr_valid   = 1'b0;
    rd_release = 1'b0;
    rd_req     = 1'b0;
    check_eq("t5_old_bank", val_t'(rd_data[7:0]), val_t'(130));
    check_eq("t5_bank_rdy", val_t'(bank_rdy), val_t'(1'b1));
    check_eq("t5_wr_ready", val_t'(wr_ready), val_t'(1'b1));
    rd(2, 3);
    check_eq("t5_new_bank", val_t'(rd_data[7:0]), val_t'(230));

    fill(50, 20);
    do_reset();
    fill(60, 42);
    check_eq("t6_not_ready", val_t'(bank_rdy), '0);
    fill(60, 1);
    check_eq("t6_ready", val_t'(bank_rdy), val_t'(1'b1));
    rd(5, 5);
    tick();

    check_eq("sb_drained", val_t'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
